// File: rtl/sdr_arb_pkg.sv
// Shared definitions for the SDRAM user-port arbiter: default widths and FSM encoding.
package sdr_arb_pkg;
  localparam int SDR_ADDR_W = 25;
  localparam int SDR_DATA_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/sdr_arb_pick.sv
// Combinational winner selection: round-robin from last+1, or fixed lowest-index
// priority when SDR_ARB_FIXED_PRI_EN is defined (the last input is then absent).
module sdr_arb_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
`ifndef SDR_ARB_FIXED_PRI_EN
  input  logic [IDX_W-1:0]     last,
`endif
  output logic [NUM_PORTS-1:0] win_oh,
  output logic [IDX_W-1:0]     win_idx
);

  logic found;
`ifndef SDR_ARB_FIXED_PRI_EN
  logic [IDX_W:0] cand;
`endif

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
`ifdef SDR_ARB_FIXED_PRI_EN
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[i]) begin
        found      = 1'b1;
        win_oh[i]  = 1'b1;
        win_idx    = IDX_W'(i);
      end
    end
`else
    cand = '0;
    // Walk last+1 .. last+NUM_PORTS, folding the sum back into range.
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = {1'b0, last} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(NUM_PORTS))
        cand = cand - (IDX_W+1)'(NUM_PORTS);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                   = 1'b1;
        win_oh[cand[IDX_W-1:0]] = 1'b1;
        win_idx                 = cand[IDX_W-1:0];
      end
    end
`endif
  end

endmodule

// File: rtl/sdr_arb.sv
// N-port arbiter in front of the SDRAM controller user port; one operation in flight.
// Define SDR_ARB_FIXED_PRI_EN for fixed lowest-index priority instead of round-robin.
module sdr_arb
  import sdr_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = SDR_ADDR_W,
  parameter int DATA_W    = SDR_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        p_req,
  input  logic [NUM_PORTS-1:0]        p_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] p_laddr,
  input  logic [NUM_PORTS*DATA_W-1:0] p_wrdata,
  output logic [NUM_PORTS-1:0]        p_done,
  output logic [DATA_W-1:0]           p_rddata,
  output logic                        m_req,
  output logic                        m_we,
  output logic [ADDR_W-1:0]           m_laddr,
  output logic [DATA_W-1:0]           m_wrdata,
  input  logic                        m_done,
  input  logic [DATA_W-1:0]           m_rddata,
  output logic [NUM_PORTS-1:0]        grant
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  state_t               state_reg, state_next;
  logic [NUM_PORTS-1:0] grant_reg;
  logic [NUM_PORTS-1:0] win_oh;
  logic [IDX_W-1:0]     win_idx;
`ifndef SDR_ARB_FIXED_PRI_EN
  logic [IDX_W-1:0]     owner_reg;
  logic [IDX_W-1:0]     last_reg;
`endif

  sdr_arb_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req     (p_req),
`ifndef SDR_ARB_FIXED_PRI_EN
    .last    (last_reg),
`endif
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|p_req) state_next = BUSY;
      BUSY:    if (m_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ownership bookkeeping; last pointer reset so port 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_reg <= '0;
`ifndef SDR_ARB_FIXED_PRI_EN
      owner_reg <= '0;
      last_reg  <= IDX_W'(NUM_PORTS-1);
`endif
    end else if (state_reg == IDLE && |p_req) begin
      grant_reg <= win_oh;
`ifndef SDR_ARB_FIXED_PRI_EN
      owner_reg <= win_idx;
`endif
    end else if (state_reg == BUSY && m_done) begin
      grant_reg <= '0;
`ifndef SDR_ARB_FIXED_PRI_EN
      last_reg  <= owner_reg;
`endif
    end
  end

`ifdef SDR_ARB_FIXED_PRI_EN
  logic unused_idx;
  assign unused_idx = ^win_idx;
`endif

  always_comb begin
    m_req    = (state_reg == BUSY);
    grant    = grant_reg;
    p_done   = {NUM_PORTS{m_done}} & grant_reg;
    p_rddata = m_rddata;
    m_we     = 1'b0;
    m_laddr  = '0;
    m_wrdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_reg[i]) begin
        m_we     = m_we | p_we[i];
        m_laddr  = m_laddr | p_laddr[i*ADDR_W +: ADDR_W];
        m_wrdata = m_wrdata | p_wrdata[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_sdr_arb.sv
// Directed bench for sdr_arb (default round-robin build): vector table plus corner sequences.
module tb_sdr_arb;
  localparam int N  = 4;
  localparam int AW = 25;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    p_req = '0;
  logic [N-1:0]    p_we = 4'b1100;
  logic [N*AW-1:0] p_laddr;
  logic [N*DW-1:0] p_wrdata;
  logic [N-1:0]    p_done;
  logic [DW-1:0]   p_rddata;
  logic            m_req, m_we;
  logic [AW-1:0]   m_laddr;
  logic [DW-1:0]   m_wrdata;
  logic            m_done = 1'b0;
  logic [DW-1:0]   m_rddata = '0;
  logic [N-1:0]    grant;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] addr_c [N];
  logic [DW-1:0] wd_c   [N];

  always #5 clk = ~clk;

  sdr_arb #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .p_req(p_req), .p_we(p_we), .p_laddr(p_laddr),
    .p_wrdata(p_wrdata), .p_done(p_done), .p_rddata(p_rddata), .m_req(m_req),
    .m_we(m_we), .m_laddr(m_laddr), .m_wrdata(m_wrdata), .m_done(m_done),
    .m_rddata(m_rddata), .grant(grant)
  );

  typedef struct {
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  e_grant;
    logic          e_mreq;
    logic [N-1:0]  e_pdone;
    logic          e_we;
    logic [AW-1:0] e_laddr;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    p_req = '0;
    m_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits at negedges for m_req, at most 4 cycles; expiry counts as a failure.
  task automatic wait_mreq(input string name);
    int n = 0;
    while (m_req !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(m_req), 64'd1);
  endtask

  initial begin
    addr_c[0] = 25'h0000100;
    addr_c[1] = 25'h0000101;
    addr_c[2] = 25'h0001234;
    addr_c[3] = 25'h0000103;
    for (int i = 0; i < N; i++) begin
      wd_c[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      p_laddr[i*AW +: AW]  = addr_c[i];
      p_wrdata[i*DW +: DW] = wd_c[i];
    end

    //        req      done  grant    mreq  pdone    we    laddr
    vt[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 25'h0};
    vt[1]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 25'h0};
    vt[2]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1, 25'h0001234};
    vt[3]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 25'h0001234};
    vt[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 25'h0};
    vt[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 25'h0};
    vt[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 25'h0};
    vt[7]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 4'b0000, 1'b1, 25'h0000103};
    vt[8]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1, 25'h0000103};
    vt[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 25'h0};
    vt[10] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b0, 25'h0000100};
    vt[11] = '{4'b1010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 25'h0};
    vt[12] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0, 25'h0000101};
    vt[13] = '{4'b1010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 25'h0};
    vt[14] = '{4'b0010, 1'b0, 4'b1000, 1'b1, 4'b0000, 1'b1, 25'h0000103};
    vt[15] = '{4'b0010, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1, 25'h0000103};
    vt[16] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 25'h0};
    vt[17] = '{4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 25'h0000101};
    vt[18] = '{4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0, 25'h0000101};
    vt[19] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 25'h0};

    // Reset state
    #2;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_mreq", 64'(m_req), 64'd0);
    chk("rst_mladdr", 64'(m_laddr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 20; v++) begin
      @(negedge clk);
      p_req  = vt[v].req;
      m_done = vt[v].done;
      #1;
      chk($sformatf("v%0d_grant", v), 64'(grant), 64'(vt[v].e_grant));
      chk($sformatf("v%0d_mreq", v), 64'(m_req), 64'(vt[v].e_mreq));
      chk($sformatf("v%0d_pdone", v), 64'(p_done), 64'(vt[v].e_pdone));
      chk($sformatf("v%0d_mwe", v), 64'(m_we), 64'(vt[v].e_we));
      chk($sformatf("v%0d_mladdr", v), 64'(m_laddr), 64'(vt[v].e_laddr));
      $display("vec %0d req=%b done=%b grant=%b m_req=%b p_done=%b", v, p_req, m_done, grant, m_req, p_done);
    end

    // All four requesting after reset: order 0,1,2,3,0,1,2,3 with one idle gap.
    do_reset();
    p_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      wait_mreq($sformatf("rr%0d_mreq", k));
      chk($sformatf("rr%0d_grant", k), 64'(grant), 64'(4'b0001 << (k % 4)));
      chk($sformatf("rr%0d_wdata", k), m_wrdata, wd_c[k % 4]);
      m_done = 1'b1;
      #1;
      chk($sformatf("rr%0d_pdone", k), 64'(p_done), 64'(4'b0001 << (k % 4)));
      @(negedge clk);
      m_done = 1'b0;
      #1;
      chk($sformatf("rr%0d_gap", k), 64'({m_req, grant}), 64'd0);
      $display("rr op %0d grant=%b", k, 4'b0001 << (k % 4));
    end

    // Port 1 read returning data.
    do_reset();
    p_req = 4'b0010;
    @(negedge clk);
    wait_mreq("rd_mreq");
    chk("rd_mwe", 64'(m_we), 64'd0);
    m_done   = 1'b1;
    m_rddata = 64'hDEADBEEF_CAFEF00D;
    p_req    = 4'b0000;
    #1;
    chk("rd_rddata", p_rddata, 64'hDEADBEEF_CAFEF00D);
    chk("rd_pdone", 64'(p_done), 64'(4'b0010));
    $display("read op p_rddata=%h p_done=%b", p_rddata, p_done);
    @(negedge clk);
    m_done = 1'b0;

    // Async reset while busy, then port 0 wins first.
    @(negedge clk);
    p_req = 4'b1000;
    @(negedge clk);
    wait_mreq("ar_mreq");
    chk("ar_grant_busy", 64'(grant), 64'(4'b1000));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_grant_rst", 64'(grant), 64'd0);
    chk("ar_mreq_rst", 64'(m_req), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    p_req = 4'b1111;
    @(negedge clk);
    wait_mreq("ar_mreq2");
    chk("ar_first", 64'(grant), 64'(4'b0001));
    $display("async reset op grant_after=%b", grant);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
